cam_sched: RTL

CAM_SCHED -- requirements
Module: cam_sched

---
 rtl/cam_pkg.sv | 28 ++
 rtl/cam_rr_arb.sv | 50 +++++
 rtl/cam_sched.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pkg.sv
// -----------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the CAM request scheduler:
//   - default CAM geometry (entry count, index width, key width)
//   - operation encodings carried on a_op / b_op
//   - scheduler FSM state type
// Build option: CAM_SCHED_LEARN_EN adds the LEARN state (miss -> auto-insert).
// -----------------------------------------------------------------------------
package cam_pkg;

    localparam int CAM_NB_MEM    = 16;
    localparam int CAM_SIZE_ADDR = 4;
    localparam int CAM_KEY_W     = 8;

    localparam logic OP_WRITE  = 1'b1;
    localparam logic OP_SEARCH = 1'b0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
`ifdef CAM_SCHED_LEARN_EN
        LEARN = 3'd3,
`endif
        RESP  = 3'd4
    } state_e;

endpackage : cam_pkg

// File: rtl/cam_rr_arb.sv
// -----------------------------------------------------------------------------
// cam_rr_arb
// Two-requester round-robin arbiter with a last-grant pointer.
// When both request, the one not granted last wins; after reset A wins.
// The pointer only advances when en is high and a grant is actually issued.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           arbitration enabled this cycle
//   req[1:0]     requests, bit 0 = A, bit 1 = B
//   gnt[1:0]     one-hot grant (combinational, zero when en is low)
// -----------------------------------------------------------------------------
module cam_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // High when B holds priority for the next contended cycle.
    logic b_next_r;

    // Grant decode from requests and the priority pointer.
    always_comb begin
        gnt = 2'b00;
        if (!en) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = b_next_r ? 2'b10 : 2'b01;
        end else if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end else begin
            gnt = 2'b00;
        end
    end

    // Priority pointer: the requester just served drops to lower priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_next_r <= 1'b0;
        end else if (en && (req != 2'b00)) begin
            b_next_r <= gnt[0];
        end else begin
            b_next_r <= b_next_r;
        end
    end

endmodule : cam_rr_arb

// File: rtl/cam_sched.sv
// -----------------------------------------------------------------------------
// cam_sched
// Schedules search / write requests from two requesters (A, B) onto a single
// CAM port. One request is in flight at a time; the FSM walks
// IDLE -> ISSUE -> (WAIT -> [LEARN] ->) RESP -> IDLE.
//
// Timing, counting the cycle where a_gnt/b_gnt is high as cycle 0:
//   write             : rsp_valid in cycle 2
//   search            : rsp_valid in cycle 3
//   search with learn : rsp_valid in cycle 4
// rsp_* is the registered image of the RESP state, so it shows one cycle after
// RESP while the FSM is already back in IDLE arbitrating the next request.
//
// Build option:
//   CAM_SCHED_LEARN_EN  defined   -> search miss writes the key at learn_ptr
//                       undefined -> miss reports found=0, index=0
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/b_req                requests
//   a_op/b_op                  1 = write, 0 = search
//   a_addr/b_addr              write index
//   a_key/b_key                write data / search key
//   a_gnt/b_gnt                one-cycle grant pulse
//   rsp_valid                  one-cycle completion pulse
//   rsp_port                   0 = A, 1 = B
//   rsp_found                  search hit (0 for writes)
//   rsp_index                  matched / written index
//   busy                       FSM not in IDLE
//   cam_enable, cam_write      CAM controls
//   cam_addr, cam_data         CAM address ({0,index}) and data/key
//   cam_out                    CAM OR-combined match index (combinational)
//   cam_found                  CAM hit flag (registered, one cycle after search)
// -----------------------------------------------------------------------------
module cam_sched
    import cam_pkg::*;
#(
    parameter int NB_MEM    = CAM_NB_MEM,
    parameter int SIZE_ADDR = CAM_SIZE_ADDR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   a_req,
    input  logic                   a_op,
    input  logic [SIZE_ADDR-1:0]   a_addr,
    input  logic [CAM_KEY_W-1:0]   a_key,
    input  logic                   b_req,
    input  logic                   b_op,
    input  logic [SIZE_ADDR-1:0]   b_addr,
    input  logic [CAM_KEY_W-1:0]   b_key,
    output logic                   a_gnt,
    output logic                   b_gnt,
    output logic                   rsp_valid,
    output logic                   rsp_port,
    output logic                   rsp_found,
    output logic [SIZE_ADDR-1:0]   rsp_index,
    output logic                   busy,
    output logic                   cam_enable,
    output logic                   cam_write,
    output logic [SIZE_ADDR:0]     cam_addr,
    output logic [CAM_KEY_W-1:0]   cam_data,
    input  logic [SIZE_ADDR:0]     cam_out,
    input  logic                   cam_found
);

    state_e                 state_r;
    logic                   gnt_a_r;
    logic                   gnt_b_r;
    logic                   op_r;
    logic [SIZE_ADDR-1:0]   addr_r;
    logic [CAM_KEY_W-1:0]   key_r;
    logic                   port_r;
    logic [SIZE_ADDR-1:0]   index_r;
    logic                   found_r;
    logic                   rsp_valid_r;
    logic                   rsp_port_r;
    logic                   rsp_found_r;
    logic [SIZE_ADDR-1:0]   rsp_index_r;
    logic                   busy_r;
    logic                   cam_enable_r;
    logic                   cam_write_r;
    logic [SIZE_ADDR:0]     cam_addr_r;
    logic [CAM_KEY_W-1:0]   cam_data_r;

    logic                   arb_en_s;
    logic [1:0]             arb_gnt_s;
    logic                   sel_op_s;
    logic [SIZE_ADDR-1:0]   sel_addr_s;
    logic [CAM_KEY_W-1:0]   sel_key_s;
    logic                   unused_s;

`ifdef CAM_SCHED_LEARN_EN
    localparam logic [SIZE_ADDR-1:0] LAST_PTR = SIZE_ADDR'(NB_MEM - 1);
    logic [SIZE_ADDR-1:0]   learn_ptr_r;
    // The CAM index space never reaches bit SIZE_ADDR of cam_out.
    assign unused_s = cam_out[SIZE_ADDR];
`else
    // Without learning, the latched key and entry count have no consumer.
    assign unused_s = ^{cam_out[SIZE_ADDR], key_r, NB_MEM[0]};
`endif

    // Arbitration only happens while idle.
    assign arb_en_s = (state_r == IDLE);

    cam_rr_arb u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (arb_en_s),
        .req   ({b_req, a_req}),
        .gnt   (arb_gnt_s)
    );

    // Mux the granted requester's operands; they are only consumed into registers.
    always_comb begin
        sel_op_s   = a_op;
        sel_addr_s = a_addr;
        sel_key_s  = a_key;
        if (arb_gnt_s[1]) begin
            sel_op_s   = b_op;
            sel_addr_s = b_addr;
            sel_key_s  = b_key;
        end else begin
            sel_op_s   = a_op;
            sel_addr_s = a_addr;
            sel_key_s  = a_key;
        end
    end

    // Scheduler FSM with all outputs registered. CAM controls are loaded on
    // the edge entering ISSUE/LEARN so they are valid during that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            gnt_a_r      <= 1'b0;
            gnt_b_r      <= 1'b0;
            op_r         <= 1'b0;
            addr_r       <= {SIZE_ADDR{1'b0}};
            key_r        <= {CAM_KEY_W{1'b0}};
            port_r       <= 1'b0;
            index_r      <= {SIZE_ADDR{1'b0}};
            found_r      <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_port_r   <= 1'b0;
            rsp_found_r  <= 1'b0;
            rsp_index_r  <= {SIZE_ADDR{1'b0}};
            busy_r       <= 1'b0;
            cam_enable_r <= 1'b0;
            cam_write_r  <= 1'b0;
            cam_addr_r   <= {(SIZE_ADDR+1){1'b0}};
            cam_data_r   <= {CAM_KEY_W{1'b0}};
`ifdef CAM_SCHED_LEARN_EN
            learn_ptr_r  <= {SIZE_ADDR{1'b0}};
`endif
        end else begin
            // Pulses and CAM controls default low; states below raise them.
            gnt_a_r      <= 1'b0;
            gnt_b_r      <= 1'b0;
            cam_enable_r <= 1'b0;
            cam_write_r  <= 1'b0;
            cam_addr_r   <= {(SIZE_ADDR+1){1'b0}};
            cam_data_r   <= {CAM_KEY_W{1'b0}};
            // Completion image of RESP; fields stay zero outside the pulse.
            rsp_valid_r  <= (state_r == RESP);
            rsp_port_r   <= (state_r == RESP) && port_r;
            rsp_found_r  <= (state_r == RESP) && found_r;
            rsp_index_r  <= (state_r == RESP) ? index_r : {SIZE_ADDR{1'b0}};

            case (state_r)
                IDLE: begin
                    if (arb_gnt_s != 2'b00) begin
                        gnt_a_r      <= arb_gnt_s[0];
                        gnt_b_r      <= arb_gnt_s[1];
                        port_r       <= arb_gnt_s[1];
                        op_r         <= sel_op_s;
                        addr_r       <= sel_addr_s;
                        key_r        <= sel_key_s;
                        cam_enable_r <= 1'b1;
                        cam_write_r  <= sel_op_s;
                        cam_addr_r   <= {1'b0, sel_addr_s};
                        cam_data_r   <= sel_key_s;
                        busy_r       <= 1'b1;
                        state_r      <= ISSUE;
                    end else begin
                        busy_r       <= 1'b0;
                        state_r      <= IDLE;
                    end
                end

                ISSUE: begin
                    if (op_r == OP_WRITE) begin
                        index_r <= addr_r;
                        found_r <= 1'b0;
                        state_r <= RESP;
                    end else begin
                        // Multiple matches pass through as the CAM's OR.
                        index_r <= cam_out[SIZE_ADDR-1:0];
                        state_r <= WAIT;
                    end
                end

                WAIT: begin
                    found_r <= cam_found;
                    if (cam_found) begin
                        state_r <= RESP;
                    end else begin
`ifdef CAM_SCHED_LEARN_EN
                        cam_enable_r <= 1'b1;
                        cam_write_r  <= 1'b1;
                        cam_addr_r   <= {1'b0, learn_ptr_r};
                        cam_data_r   <= key_r;
                        state_r      <= LEARN;
`else
                        index_r      <= {SIZE_ADDR{1'b0}};
                        state_r      <= RESP;
`endif
                    end
                end

`ifdef CAM_SCHED_LEARN_EN
                LEARN: begin
                    index_r     <= learn_ptr_r;
                    found_r     <= 1'b0;
                    learn_ptr_r <= (learn_ptr_r == LAST_PTR) ? {SIZE_ADDR{1'b0}}
                                                             : learn_ptr_r + 1'b1;
                    state_r     <= RESP;
                end
`endif

                RESP: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end

                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign a_gnt      = gnt_a_r;
    assign b_gnt      = gnt_b_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_port   = rsp_port_r;
    assign rsp_found  = rsp_found_r;
    assign rsp_index  = rsp_index_r;
    assign busy       = busy_r;
    assign cam_enable = cam_enable_r;
    assign cam_write  = cam_write_r;
    assign cam_addr   = cam_addr_r;
    assign cam_data   = cam_data_r;

endmodule : cam_sched
